// File: rtl/adder_pipe.sv
// Single-stage add/sub/accumulate/chain unit behind a valid/ready skid-free output register,
// with a carry-out delay line that advances once per consumed result.
module adder_pipe #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             cout,
  output logic             ovf,
  output logic             cout_dly,
  output logic [15:0]      txn_cnt
);

  typedef enum logic [1:0] {M_ADD = 2'b00, M_SUB = 2'b01, M_ACC = 2'b10, M_CHAIN = 2'b11} mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c;
  } addop_t;

  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic [DEPTH-1:0] dly;
  addop_t           op;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic             accept, pop;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign cout_dly = dly[DEPTH-1];

  // Steer the three adder inputs per mode; SUB is a + ~b + 1 so cout means no-borrow.
  always_comb begin
    op = '{x: a, y: b, c: cin};
    unique case (mode_e'(mode))
      M_ADD:   op = '{x: a,   y: b,  c: cin};
      M_SUB:   op = '{x: a,   y: ~b, c: 1'b1};
      M_ACC:   op = '{x: acc, y: a,  c: cin};
      M_CHAIN: op = '{x: a,   y: b,  c: carry_q};
      default: op = '{x: a,   y: b,  c: cin};
    endcase
  end

  assign sum     = {1'b0, op.x} + {1'b0, op.y} + {{WIDTH{1'b0}}, op.c};
  assign sum_ovf = (op.x[WIDTH-1] == op.y[WIDTH-1]) && (sum[WIDTH-1] != op.x[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!clr) begin
      out_valid <= 1'b0;
      d_out     <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
      carry_q   <= 1'b0;
      dly       <= '0;
      txn_cnt   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        d_out     <= sum[WIDTH-1:0];
        cout      <= sum[WIDTH];
        ovf       <= sum_ovf;
        carry_q   <= sum[WIDTH];
        txn_cnt   <= txn_cnt + 16'd1;
        if (mode_e'(mode) == M_ACC) acc <= sum[WIDTH-1:0];
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      // cout still holds the result being consumed, even when a new one lands this edge.
      if (pop) dly <= DEPTH'({dly, cout});
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Table-driven bench for adder_pipe (WIDTH=8, DEPTH=2) with a result scoreboard queue.
module tb_adder_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             clr, in_valid, in_ready, cin, out_valid, out_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a, b, d_out;
  logic             cout, ovf, cout_dly;
  logic [15:0]      txn_cnt;

  adder_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .d_out(d_out), .cout(cout), .ovf(ovf), .cout_dly(cout_dly), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       o;
  } res_t;

  typedef struct {
    logic [1:0] m;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    res_t       exp;
  } vec_t;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CHN = 2'b11;

  res_t        q[$];
  int unsigned cmps = 0, errs = 0;
  logic [1:0]  dly_m = '0;
  logic [15:0] txn_m = '0;
  logic        rst_seen = 1'b0;
  logic        acc_now;
  res_t        e;
  vec_t        tbl[17];
  logic [15:0] t0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called aligned at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input res_t ex);
    in_valid = 1'b1; mode = m; a = av; b = bv; cin = ci;
    for (int t = 0; t < 50; t++) begin
      #2;
      if (in_ready) begin
        q.push_back(ex);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); mode = 2'($urandom);
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: outputs must match the oldest outstanding expectation whenever valid.
  always @(negedge clk) begin
    if (!clr) begin
      q.delete();
      dly_m    <= '0;
      txn_m    <= '0;
      rst_seen <= 1'b1;
    end else if (rst_seen) begin
      acc_now = in_valid && in_ready;
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      chk("out_valid", 32'(out_valid), 32'(q.size() > (acc_now ? 1 : 0)));
      chk("cout_dly", 32'(cout_dly), 32'(dly_m[1]));
      chk("txn_cnt", 32'(txn_cnt), 32'(txn_m));
      if (out_valid && q.size() > 0) begin
        e = q[0];
        chk("d_out", 32'(d_out), 32'(e.d));
        chk("cout", 32'(cout), 32'(e.c));
        chk("ovf", 32'(ovf), 32'(e.o));
        if (out_ready) begin
          dly_m <= {dly_m[0], e.c};
          void'(q.pop_front());
        end
      end
      if (acc_now) txn_m <= txn_m + 16'd1;
    end
  end

  initial begin
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = '0; a = '0; b = '0; cin = 1'b0;

    // Sequence starts from reset: acc=0, carry_q=0.
    tbl[0]  = '{ADD, 8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}};
    tbl[1]  = '{SUB, 8'h05, 8'h07, 1'b1, '{8'hFE, 1'b0, 1'b0}};
    tbl[2]  = '{SUB, 8'h80, 8'h01, 1'b0, '{8'h7F, 1'b1, 1'b1}};
    tbl[3]  = '{ADD, 8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0}};
    tbl[4]  = '{CHN, 8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}};
    tbl[5]  = '{CHN, 8'h01, 8'h00, 1'b0, '{8'h02, 1'b0, 1'b0}};
    tbl[6]  = '{ACC, 8'h80, 8'hAA, 1'b0, '{8'h80, 1'b0, 1'b0}};
    tbl[7]  = '{ADD, 8'h12, 8'h34, 1'b1, '{8'h47, 1'b0, 1'b0}};
    tbl[8]  = '{ACC, 8'h80, 8'h55, 1'b0, '{8'h00, 1'b1, 1'b1}};
    tbl[9]  = '{ACC, 8'h80, 8'h00, 1'b0, '{8'h80, 1'b0, 1'b0}};
    tbl[10] = '{ADD, 8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1}};
    tbl[11] = '{CHN, 8'h10, 8'h20, 1'b1, '{8'h30, 1'b0, 1'b0}};
    tbl[12] = '{SUB, 8'h07, 8'h07, 1'b0, '{8'h00, 1'b1, 1'b0}};
    tbl[13] = '{CHN, 8'h01, 8'h01, 1'b0, '{8'h03, 1'b0, 1'b0}};
    tbl[14] = '{ADD, 8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0}};
    tbl[15] = '{SUB, 8'h00, 8'h80, 1'b0, '{8'h80, 1'b0, 1'b1}};
    tbl[16] = '{ACC, 8'h05, 8'hFF, 1'b1, '{8'h86, 1'b0, 1'b0}};

    idle(2);
    clr = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d_out", 32'(d_out), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_cout_dly", 32'(cout_dly), 32'd0);
    chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (tbl[i]) send(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp);
    idle(2);

    // Backpressure: result held, second operand blocked, then pop+accept on release.
    out_ready = 1'b0;
    send(ADD, 8'h11, 8'h22, 1'b0, '{8'h33, 1'b0, 1'b0});
    t0 = txn_cnt;
    fork
      send(ADD, 8'h01, 8'h02, 1'b0, '{8'h03, 1'b0, 1'b0});
      begin
        repeat (4) begin
          #2;
          chk("hold_in_ready", 32'(in_ready), 32'd0);
          chk("hold_d_out", 32'(d_out), 32'h33);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    chk("hold_txn_cnt", 32'(txn_cnt), 32'(t0 + 16'd1));
    chk("release_out_valid", 32'(out_valid), 32'd1);
    chk("release_d_out", 32'(d_out), 32'h03);
    idle(2);

    // Reset mid-stream with a held result and cout_dly=1.
    send(ADD, 8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0});
    send(ADD, 8'hFF, 8'h02, 1'b0, '{8'h01, 1'b1, 1'b0});
    idle(1);
    out_ready = 1'b0;
    send(ADD, 8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1});
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_cout_dly", 32'(cout_dly), 32'd1);
    clr = 1'b0; in_valid = 1'b1; mode = ADD; a = 8'h01; b = 8'h01; out_ready = 1'b1;
    idle(1);
    clr = 1'b1; in_valid = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_d_out", 32'(d_out), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_cout_dly", 32'(cout_dly), 32'd0);
    chk("mid_rst_txn_cnt", 32'(txn_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    send(ADD, 8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0});
    send(ADD, 8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0});
    send(ADD, 8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0});
    idle(2);
    chk("dly_after_101", 32'(cout_dly), 32'd0);

    // Counter wrap: 3 + 65534 accepts lands on 1.
    in_valid = 1'b1; mode = ADD; a = 8'h00; b = 8'h00; cin = 1'b0;
    for (int n = 0; n < 65534; n++) begin
      #2;
      q.push_back('{8'h00, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("txn_wrap", 32'(txn_cnt), 32'd1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 128: operand/result width; legal 2..256.
REQ-002 SHALL have parameter DEPTH, default 8: carry-out delay-line length; legal 1..256.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-low: sampled on rising clk, state cleared while clr=0.
REQ-005 SHALL have port in_valid  input  1  operand transfer request.
REQ-006 SHALL have port in_ready  output  1  block can accept operands this cycle.
REQ-007 SHALL have port mode  input  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CHAIN.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port cin  input  1  carry in for ADD/ACC.
REQ-011 SHALL have port out_valid  output  1  result held on d_out/cout/ovf.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port d_out  output  WIDTH  registered result.
REQ-014 SHALL have port cout  output  1  registered carry/no-borrow of result.
REQ-015 SHALL have port ovf  output  1  registered two's-complement signed overflow of result.
REQ-016 SHALL have port cout_dly  output  1  cout delayed DEPTH output transfers.
REQ-017 SHALL have port txn_cnt  output  16  count of accepted operand transfers, wraps at 2^16.

Function
REQ-018 Accept SHALL occur when in_valid=1 and in_ready=1; pop SHALL occur when out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL equal (!out_valid | out_ready) combinationally; it SHALL NOT depend on in_valid.
REQ-020 Latency SHALL be 1 cycle: result of an accept is on d_out with out_valid=1 at the next rising edge.
REQ-021 Simultaneous pop and accept SHALL replace the output register with the new result, out_valid staying 1.
REQ-022 Pop without accept SHALL clear out_valid; d_out/cout/ovf SHALL hold last values.
REQ-023 While out_valid=1 and out_ready=0, d_out, cout, ovf SHALL be stable and no accept SHALL occur.
REQ-024 ADD: {cout,d_out} SHALL equal a + b + cin, computed at WIDTH+1 bits.
REQ-025 SUB: {cout,d_out} SHALL equal a + ~b + 1; cout=1 means no borrow (a>=b unsigned); cin ignored.
REQ-026 ACC: {cout,d_out} SHALL equal acc + a + cin; internal acc register SHALL take d_out value on the same edge; b ignored.
REQ-027 CHAIN: {cout,d_out} SHALL equal a + b + carry_q, carry_q being cout of the previous accepted operation (0 after reset); cin ignored.
REQ-028 carry_q SHALL update on every accept in all modes.
REQ-029 acc SHALL change only on ACC accepts; wrap modulo 2^WIDTH, cout flags the wrap.
REQ-030 ovf SHALL be 1 when operands driving the MSB have equal sign and result sign differs (SUB: sign of a vs ~b).
REQ-031 Delay line SHALL shift cout of the popped result in on each pop; cout_dly SHALL equal the stage DEPTH-1 output; no shift without a pop.
REQ-032 DEPTH=1 SHALL give cout_dly = cout of the most recently popped result.
REQ-033 txn_cnt SHALL increment by 1 per accept, 0xFFFF+1 -> 0x0000.
REQ-034 mode, a, b, cin SHALL only be sampled on accept cycles.

Reset
REQ-035 With clr=0 at a rising edge: out_valid=0, d_out=0, cout=0, ovf=0, cout_dly=0, all delay stages=0, acc=0, carry_q=0, txn_cnt=0.
REQ-036 Reset SHALL override any concurrent accept or pop; an in-flight result SHALL be discarded.
REQ-037 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (WIDTH=8, DEPTH=2 unless stated)
REQ-038 ADD a=0xFF,b=0x01,cin=0, out_ready=1 -> next cycle d_out=0x00,cout=1,ovf=0,out_valid=1.
REQ-039 SUB a=0x05,b=0x07 -> d_out=0xFE,cout=0; then SUB a=0x80,b=0x01 -> d_out=0x7F,cout=1,ovf=1.
REQ-040 CHAIN two-word 16-bit add 0x01FF+0x0001: words (0xFF,0x01) then (0x01,0x00) -> d_out 0x00 then 0x02; cout 1 then 0.
REQ-041 ACC a=0x80,cin=0 three times, interleaved with one ADD -> acc results 0x80, 0x00(cout=1), 0x80; ADD does not disturb acc.
REQ-042 Hold out_ready=0 4 cycles with in_valid=1 -> in_ready=0, d_out stable, txn_cnt +1 only; release -> pop and accept same cycle.
REQ-043 Assert clr=0 mid-stream with out_valid=1 and cout_dly=1 -> next edge all outputs 0, txn_cnt=0; then pops 1,0,1 of cout -> cout_dly follows two pops late.
